// File: rtl/solar_motor_drv.sv
// Two-axis solar tracker stepper driver: turns level-held N/E/S/W move requests
// into divided step pulses with position tracking, limit blocking and a settle delay.
module solar_motor_drv #(
  parameter int unsigned STEP_DIV   = 16,
  parameter int unsigned SETTLE_CYC = 32,
  parameter int unsigned POS_HOME   = 128,
  parameter int unsigned POS_MAX    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mn,
  input  logic       me,
  input  logic       ms,
  input  logic       mw,
  output logic       step_ns,
  output logic       step_ew,
  output logic       dir_ns,
  output logic       dir_ew,
  output logic [7:0] pos_ns,
  output logic [7:0] pos_ew,
  output logic       busy,
  output logic       at_limit,
  output logic       fault
);

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 8;
  localparam logic [PW-1:0] PMAX     = PW'(POS_MAX);
  localparam logic [PW-1:0] PHOME    = PW'(POS_HOME);
  localparam logic [CW-1:0] DIV_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          axis_q, axis_d;   // 1 = pan (E/W) axis latched
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_ns_d, pos_ew_d;
  logic          dir_ns_d, dir_ew_d, step_ns_d, step_ew_d, busy_d, fault_d;

  logic [2:0]    req_cnt;
  logic          one_req, multi_req, req_ew, req_inc, req_blocked;
  logic [PW-1:0] req_pos, lat_pos;
  logic          lat_dir, lat_req, lat_blocked, exit_req;

  // Request decode for the IDLE accept decision
  assign req_cnt     = 3'(mn) + 3'(me) + 3'(ms) + 3'(mw);
  assign one_req     = (req_cnt == 3'd1);
  assign multi_req   = (req_cnt > 3'd1);
  assign req_ew      = me | mw;
  assign req_inc     = mn | me;
  assign req_pos     = req_ew ? pos_ew : pos_ns;
  assign req_blocked = req_inc ? (req_pos == PMAX) : (req_pos == '0);

  // Latched move: any request pattern other than "only the latched one" ends it
  assign lat_dir     = axis_q ? dir_ew : dir_ns;
  assign lat_pos     = axis_q ? pos_ew : pos_ns;
  assign lat_req     = axis_q ? (dir_ew ? me : mw) : (dir_ns ? mn : ms);
  assign lat_blocked = lat_dir ? (lat_pos == PMAX) : (lat_pos == '0);
  assign exit_req    = !lat_req || multi_req;

  assign at_limit = (state == IDLE) ? (one_req && req_blocked) : lat_blocked;

  always_comb begin
    state_d   = state;
    axis_d    = axis_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    pos_ns_d  = pos_ns;
    pos_ew_d  = pos_ew;
    dir_ns_d  = dir_ns;
    dir_ew_d  = dir_ew;
    step_ns_d = 1'b0;
    step_ew_d = 1'b0;
    fault_d   = multi_req;
    unique case (state)
      IDLE: begin
        div_d = '0;
        cnt_d = '0;
        if (one_req && !req_blocked) begin
          state_d = MOVE;
          axis_d  = req_ew;
          if (req_ew) dir_ew_d = req_inc;
          else        dir_ns_d = req_inc;
        end
      end
      MOVE: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
        if (div_q == DIV_LAST && !lat_blocked) begin
          if (axis_q) begin
            step_ew_d = 1'b1;
            pos_ew_d  = lat_dir ? pos_ew + PW'(1) : pos_ew - PW'(1);
          end else begin
            step_ns_d = 1'b1;
            pos_ns_d  = lat_dir ? pos_ns + PW'(1) : pos_ns - PW'(1);
          end
        end
        if (exit_req || lat_blocked) begin
          state_d = SETTLE;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        div_d = '0;
        if (cnt_q == SET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      axis_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      pos_ns  <= PHOME;
      pos_ew  <= PHOME;
      dir_ns  <= 1'b0;
      dir_ew  <= 1'b0;
      step_ns <= 1'b0;
      step_ew <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_d;
      axis_q  <= axis_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pos_ns  <= pos_ns_d;
      pos_ew  <= pos_ew_d;
      dir_ns  <= dir_ns_d;
      dir_ew  <= dir_ew_d;
      step_ns <= step_ns_d;
      step_ew <= step_ew_d;
      busy    <= busy_d;
      fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_solar_motor_drv.sv
// Scoreboard bench for solar_motor_drv: stimulus queues expected step events and
// status checkpoints; a negedge monitor pops and compares them.
module tb_solar_motor_drv;

  logic       clk = 1'b0;
  logic       rst, mn, me, ms, mw;
  logic       step_ns, step_ew, dir_ns, dir_ew, busy, at_limit, fault;
  logic [7:0] pos_ns, pos_ew;

  solar_motor_drv #(
    .STEP_DIV(4), .SETTLE_CYC(8), .POS_HOME(128), .POS_MAX(255)
  ) dut (
    .clk(clk), .rst(rst), .mn(mn), .me(me), .ms(ms), .mw(mw),
    .step_ns(step_ns), .step_ew(step_ew), .dir_ns(dir_ns), .dir_ew(dir_ew),
    .pos_ns(pos_ns), .pos_ew(pos_ew), .busy(busy), .at_limit(at_limit),
    .fault(fault)
  );

  typedef struct {
    int         cyc;
    logic       ew;
    logic [7:0] pos;
    logic       dir;
  } step_t;

  typedef struct {
    int         cyc;
    string      name;
    logic [20:0] exp;
  } chk_t;

  step_t step_q[$];
  chk_t  chk_q[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;
  int    t;

  step_t       s_pop;
  chk_t        c_pop;
  logic [20:0] got_v;
  logic [7:0]  s_pos;
  logic        s_dir;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_step(input int cy, input logic ew, input int pos, input logic dir);
    step_t s;
    s.cyc = cy; s.ew = ew; s.pos = 8'(pos); s.dir = dir;
    step_q.push_back(s);
  endtask

  // Expected {pos_ns, pos_ew, dir_ns, dir_ew, busy, fault, at_limit} at edge count cy
  task automatic exp_chk(input int cy, input string nm, input int pns, input int pew,
                         input logic dns, input logic dew, input logic bsy,
                         input logic flt, input logic lim);
    chk_t c;
    c.cyc = cy; c.name = nm;
    c.exp = {8'(pns), 8'(pew), dns, dew, bsy, flt, lim};
    chk_q.push_back(c);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (step_ns === 1'b1 || step_ew === 1'b1) begin
        vectors++;
        if (step_q.size() == 0) begin
          miscompares++;
          $display("FAIL step_unexpected cyc=%0d got step_ns=%b step_ew=%b pos_ns=%0d pos_ew=%0d, required no step",
                   cyc, step_ns, step_ew, pos_ns, pos_ew);
        end else begin
          s_pop = step_q.pop_front();
          s_pos = s_pop.ew ? pos_ew : pos_ns;
          s_dir = s_pop.ew ? dir_ew : dir_ns;
          if (cyc != s_pop.cyc || step_ew !== s_pop.ew || step_ns !== !s_pop.ew ||
              s_pos !== s_pop.pos || s_dir !== s_pop.dir)
          begin
            miscompares++;
            $display("FAIL step_event got cyc=%0d ns=%b ew=%b pos=%0d dir=%b, required cyc=%0d ew=%b pos=%0d dir=%b",
                     cyc, step_ns, step_ew, s_pos, s_dir, s_pop.cyc, s_pop.ew, s_pop.pos, s_pop.dir);
          end
        end
      end
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c_pop = chk_q.pop_front();
        vectors++;
        got_v = {pos_ns, pos_ew, dir_ns, dir_ew, busy, fault, at_limit};
        if (got_v !== c_pop.exp || c_pop.cyc != cyc) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got {pns,pew,dns,dew,busy,fault,lim}=%h required %h at cyc %0d",
                   c_pop.name, cyc, got_v, c_pop.exp, c_pop.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mn = 1'b0; me = 1'b0; ms = 1'b0; mw = 1'b0;
    tick(2);
    rst = 1'b0;
    mon_en = 1'b1;
    exp_chk(cyc, "reset", 128, 128, 0, 0, 0, 0, 0);

    // North held 13 cycles: steps at +5, +9, +13
    tick(1);
    t = cyc;
    mn = 1'b1;
    exp_chk(t + 1, "a_move_n", 128, 128, 1, 0, 1, 0, 0);
    for (int n = 1; n <= 3; n++) exp_step(t + 1 + 4 * n, 1'b0, 128 + n, 1'b1);
    exp_chk(t + 13, "a_pos131", 131, 128, 1, 0, 1, 0, 0);
    exp_chk(t + 21, "a_settle_end", 131, 128, 1, 0, 1, 0, 0);
    exp_chk(t + 22, "a_idle", 131, 128, 1, 0, 0, 0, 0);
    tick(13);
    mn = 1'b0;
    tick(9);

    // Two requests from IDLE: fault only, no move
    t = cyc;
    mn = 1'b1; me = 1'b1;
    exp_chk(t + 1, "c_fault_idle", 131, 128, 1, 0, 0, 1, 0);
    tick(1);
    mn = 1'b0; me = 1'b0;
    exp_chk(t + 2, "c_fault_clear", 131, 128, 1, 0, 0, 0, 0);
    tick(1);

    // East move, then north joins mid-move -> SETTLE with fault
    t = cyc;
    me = 1'b1;
    exp_chk(t + 1, "c_move_e", 131, 128, 1, 1, 1, 0, 0);
    exp_step(t + 5, 1'b1, 129, 1'b1);
    tick(6);
    mn = 1'b1;
    exp_chk(t + 7, "c_multi_settle", 131, 129, 1, 1, 1, 1, 0);
    tick(1);
    mn = 1'b0; me = 1'b0;
    exp_chk(t + 8, "c_fault_drop", 131, 129, 1, 1, 1, 0, 0);
    exp_chk(t + 15, "c_idle", 131, 129, 1, 1, 0, 0, 0);
    tick(8);

    // South released mid-move, reasserted inside SETTLE
    t = cyc;
    ms = 1'b1;
    exp_chk(t + 1, "d_move_s", 131, 129, 0, 1, 1, 0, 0);
    exp_step(t + 5, 1'b0, 130, 1'b0);
    tick(6);
    ms = 1'b0;
    tick(3);
    ms = 1'b1;
    exp_chk(t + 14, "d_settle_ignore", 130, 129, 0, 1, 1, 0, 0);
    exp_chk(t + 15, "d_first_idle", 130, 129, 0, 1, 0, 0, 0);
    exp_chk(t + 16, "d_accept", 130, 129, 0, 1, 1, 0, 0);
    exp_step(t + 20, 1'b0, 129, 1'b0);
    tick(11);
    ms = 1'b0;
    exp_chk(t + 29, "d_idle2", 129, 129, 0, 1, 0, 0, 0);
    tick(9);

    // West all the way to 0, held against the limit, then east off it
    t = cyc;
    mw = 1'b1;
    exp_chk(t + 1, "b_move_w", 129, 129, 0, 0, 1, 0, 0);
    for (int n = 1; n <= 129; n++) exp_step(t + 1 + 4 * n, 1'b1, 129 - n, 1'b0);
    exp_chk(t + 516, "b_pos1", 129, 1, 0, 0, 1, 0, 0);
    exp_chk(t + 517, "b_at_zero", 129, 0, 0, 0, 1, 0, 1);
    exp_chk(t + 526, "b_idle_limit", 129, 0, 0, 0, 0, 0, 1);
    exp_chk(t + 529, "b_still_blocked", 129, 0, 0, 0, 0, 0, 1);
    tick(530);
    mw = 1'b0; me = 1'b1;
    exp_chk(t + 531, "b_move_e", 129, 0, 0, 1, 1, 0, 0);
    exp_step(t + 535, 1'b1, 1, 1'b1);
    tick(5);
    me = 1'b0;
    exp_chk(t + 544, "b_idle_pos1", 129, 1, 0, 1, 0, 0, 0);
    tick(9);

    // North to 140, then reset on what would be a step edge
    t = cyc;
    mn = 1'b1;
    exp_chk(t + 1, "e_move_n", 129, 1, 1, 1, 1, 0, 0);
    for (int n = 1; n <= 11; n++) exp_step(t + 1 + 4 * n, 1'b0, 129 + n, 1'b1);
    exp_chk(t + 48, "e_pre_rst", 140, 1, 1, 1, 1, 0, 0);
    tick(48);
    rst = 1'b1;
    exp_chk(t + 49, "e_rst", 128, 128, 0, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0; mn = 1'b0;
    exp_chk(t + 52, "e_rst_idle", 128, 128, 0, 0, 0, 0, 0);
    tick(4);

    tick(2);
    vectors++;
    if (step_q.size() != 0 || chk_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d steps and %0d checkpoints pending, required 0 and 0",
               step_q.size(), chk_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
